pipeline_adder_result_buffer: RTL and testbench

//   Sits directly downstream of pipeline_carry_skip_adder. Consumes its {cout,sum} stream and buffers results in a FIFO.
//   The adder has no stall path, so this block tracks in-flight operations with a valid delay line matching the adder latency.
//   It grants issue credits upstream (in_ready) so that a buffered result is never dropped, even when the consumer stalls.
//   It presents results to the consumer over a valid/ready interface.

---
 rtl/pipeline_adder_result_buffer.sv | 136 +++++++++++++
 tb/tb_pipeline_adder_result_buffer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_adder_result_buffer.sv
// Result buffer for a fixed-latency, non-stallable adder.
// Upstream issue is gated by a credit, so the adder can never deliver a result the FIFO cannot hold.
module pipeline_adder_result_buffer #(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned LATENCY = 4,
    parameter int unsigned DEPTH   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             sum_in,
    input  logic                         cout_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_sum,
    output logic                         out_cout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         drop_err
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned FW = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
    localparam int unsigned OW = CW + FW + 1;

    logic [LATENCY-1:0] dl_q, dl_d;
    logic [FW-1:0]      inflight_q, inflight_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [WIDTH-1:0]   head_sum_q, head_sum_d;
    logic               head_cout_q, head_cout_d;
    logic               drop_err_q, drop_err_d;

    logic [WIDTH-1:0]   mem_sum [DEPTH];
    logic               mem_cout [DEPTH];

    logic               acc;
    logic               cap;
    logic               pop;
    logic [OW-1:0]      occ;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    // Credit counts both stored results and results still inside the adder.
    assign occ      = OW'(count_q) + OW'(inflight_q);
    assign in_ready = (occ < OW'(DEPTH));
    assign acc      = in_valid & in_ready;
    assign cap      = dl_q[LATENCY-1];
    assign pop      = out_valid & out_ready;

    assign out_valid = (count_q != '0);
    assign out_sum   = head_sum_q;
    assign out_cout  = head_cout_q;
    assign count     = count_q;
    assign drop_err  = drop_err_q;

    always_comb begin
        dl_d    = dl_q;
        dl_d[0] = acc;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            dl_d[i] = dl_q[i-1];
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        unique case ({acc, cap})
            2'b10:   inflight_d = inflight_q + FW'(1);
            2'b01:   inflight_d = inflight_q - FW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_comb begin
        count_d  = count_q;
        unique case ({cap, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        wr_ptr_d = cap ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    end

    // Registered head: next entry from memory, or the incoming result when the FIFO drains to it.
    always_comb begin
        head_sum_d  = head_sum_q;
        head_cout_d = head_cout_q;
        if (pop && (count_q > CW'(1))) begin
            head_sum_d  = mem_sum[rd_ptr_d];
            head_cout_d = mem_cout[rd_ptr_d];
        end else if (cap && ((count_q == '0) || (pop && (count_q == CW'(1))))) begin
            head_sum_d  = sum_in;
            head_cout_d = cout_in;
        end
    end

    assign drop_err_d = drop_err_q | (in_valid & ~in_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_q        <= '0;
            inflight_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            head_sum_q  <= '0;
            head_cout_q <= 1'b0;
            drop_err_q  <= 1'b0;
        end else begin
            dl_q        <= dl_d;
            inflight_q  <= inflight_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            head_sum_q  <= head_sum_d;
            head_cout_q <= head_cout_d;
            drop_err_q  <= drop_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (cap) begin
            mem_sum[wr_ptr_q]  <= sum_in;
            mem_cout[wr_ptr_q] <= cout_in;
        end
    end

endmodule

// File: tb/tb_pipeline_adder_result_buffer.sv
// Bench for pipeline_adder_result_buffer with a behavioural fixed-latency adder in front of it.
// Issued operations push expected results to a queue; a monitor pops and compares on every output pop.
module tb_pipeline_adder_result_buffer;

    localparam int W  = 64;
    localparam int L  = 4;
    localparam int D  = 8;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready;
    logic [W-1:0]  sum_in;
    logic          cout_in;
    logic          out_valid, out_ready;
    logic [W-1:0]  out_sum;
    logic          out_cout;
    logic [CW-1:0] count;
    logic          drop_err;

    logic [W-1:0]  a, b;
    logic          cin;
    logic [W:0]    next_exp;
    logic [W:0]    pipe [L];
    logic [W:0]    exp_q [$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_acc = 0;
    int n_pop = 0;
    int acc_edge = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Adder stand-in: L register stages from operand sample to result.
    always @(posedge clk) begin
        pipe[0] <= {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign {cout_in, sum_in} = pipe[L-1];

    pipeline_adder_result_buffer #(.WIDTH(W), .LATENCY(L), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_in    (sum_in),
        .cout_in   (cout_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .count     (count),
        .drop_err  (drop_err)
    );

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Accept monitor: the upcoming edge accepts this operation.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) begin
            exp_q.push_back(next_exp);
            n_acc++;
            acc_edge = cyc + 1;
        end
    end

    // Output monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (count > CW'(D)) check("count_bound", 65'(count), 65'(D));
            if (out_valid && out_ready) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {out_cout, out_sum}, '1);
                end else begin
                    check("result", {out_cout, out_sum}, exp_q.pop_front());
                end
            end
        end
    end

    task automatic drive(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                         input logic [W:0] te);
        a = ta; b = tb_; cin = tc; next_exp = te; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || out_valid) && i < 200) begin
            @(negedge clk);
            i++;
        end
        check(name, 65'(exp_q.size()), 65'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0, pop0, drops, maxc, stray;
        logic seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; next_exp = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 65'(out_valid), 65'd0);
        check("rst_out_sum", 65'(out_sum), 65'd0);
        check("rst_out_cout", 65'(out_cout), 65'd0);
        check("rst_count", 65'(count), 65'd0);
        check("rst_in_ready", 65'(in_ready), 65'd1);
        check("rst_drop_err", 65'(drop_err), 65'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // T2 latency
        out_ready = 1'b1;
        drive(64'd5, 64'd200, 1'b1, {1'b0, 64'd206});
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("t2_seen", 65'(seen), 65'd1);
        check("t2_latency", 65'(cyc - acc_edge), 65'd4);
        check("t2_sum", {out_cout, out_sum}, {1'b0, 64'd206});
        drain("t2_drain");

        // T5 wrap
        drive(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, {1'b1, 64'd0});
        drive(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
              {1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
        drain("t5_drain");

        // T3 streaming
        acc0 = n_acc; pop0 = n_pop; drops = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            a = 64'(i); b = 64'(1000 * i); cin = 1'b0; next_exp = 65'(1001 * i);
            @(negedge clk);
            if (!in_ready) drops++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("t3_ready_drops", 65'(drops), 65'd0);
        check("t3_accepted", 65'(n_acc - acc0), 65'd100);
        drain("t3_drain");
        check("t3_popped", 65'(n_pop - pop0), 65'd100);
        check("t3_drop_err", 65'(drop_err), 65'd0);

        // T4 backpressure + T6 illegal issue
        out_ready = 1'b0; acc0 = n_acc; pop0 = n_pop; maxc = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a = 64'(i); b = 64'd7; cin = 1'b0; next_exp = 65'(i + 7);
            @(negedge clk);
            if (int'(count) > maxc) maxc = int'(count);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("t4_accepted", 65'(n_acc - acc0), 65'd8);
        check("t4_max_count", 65'(maxc), 65'd8);
        check("t4_in_ready_low", 65'(in_ready), 65'd0);
        check("t6_drop_err", 65'(drop_err), 65'd1);
        repeat (3) @(posedge clk);
        #1;
        check("t6_count_held", 65'(count), 65'd8);
        out_ready = 1'b1;
        @(negedge clk);
        check("t4_ready_first_pop", 65'(in_ready), 65'd0);
        @(negedge clk);
        check("t4_ready_after_pop", 65'(in_ready), 65'd1);
        drain("t4_drain");
        check("t4_popped", 65'(n_pop - pop0), 65'd8);
        check("t4_count_empty", 65'(count), 65'd0);

        // T1 reset mid-burst: 2 buffered, 3 in flight
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) drive(64'(i), 64'd50, 1'b0, 65'(i + 50));
        @(posedge clk); #1;
        check("t1_pre_count", 65'(count), 65'd2);
        rst = 1'b1;
        #1;
        check("t1_out_valid", 65'(out_valid), 65'd0);
        check("t1_count", 65'(count), 65'd0);
        check("t1_in_ready", 65'(in_ready), 65'd1);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1; stray = 0;
        for (int i = 0; i < L + 4; i++) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        check("t1_no_output", 65'(stray), 65'd0);
        check("t1_count_after", 65'(count), 65'd0);
        check("t1_drop_err", 65'(drop_err), 65'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
